// File: rtl/cpu_mem_bridge_if.sv
// cpu_mem_bridge_if: 6502 core bus plus memc request/status signals.
// master = core and memc side, slave = bridge side.
interface cpu_mem_bridge_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
);
    // Core side
    logic              cpu_valid;
    logic              cpu_rw;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_dout;
    logic              rdy;
    logic [DATA_W-1:0] cpu_din;
    logic              cpu_resp;
    logic              cpu_timeout;
    logic              fault;
    // memc side
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read_en;
    logic              mem_write_en;
    logic              mem_busy;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_error;

    modport master (
        output cpu_valid, cpu_rw, cpu_addr, cpu_dout,
        output mem_busy, mem_rdata, mem_error,
        input  rdy, cpu_din, cpu_resp, cpu_timeout, fault,
        input  mem_addr, mem_wdata, mem_read_en, mem_write_en
    );

    modport slave (
        input  cpu_valid, cpu_rw, cpu_addr, cpu_dout,
        input  mem_busy, mem_rdata, mem_error,
        output rdy, cpu_din, cpu_resp, cpu_timeout, fault,
        output mem_addr, mem_wdata, mem_read_en, mem_write_en
    );
endinterface

// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge: turns 6502 core bus cycles into single memc requests, one
// at a time, after memc BIST completes; a memc BIST error becomes a sticky
// fault that stalls the core until reset.
// Build macro BRIDGE_TIMEOUT_EN: bounds WAIT to TIMEOUT_CYCLES cycles and
// completes a stuck access with cpu_timeout=1 and all-ones read data.
module cpu_mem_bridge #(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            reset,
    cpu_mem_bridge_if.slave bus
);

    typedef enum logic [5:0] {
        S_INIT  = 6'b000001,
        S_IDLE  = 6'b000010,
        S_ISSUE = 6'b000100,
        S_WAIT  = 6'b001000,
        S_RESP  = 6'b010000,
        S_FAULT = 6'b100000
    } state_e;

    state_e            state_q, state_d;
    logic              req_rw_q, req_rw_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_data_q, req_data_d;
    logic              wait_first_q, wait_first_d;
    logic              rdy_q, rdy_d;
    logic [DATA_W-1:0] cpu_din_q, cpu_din_d;
    logic              cpu_resp_q, cpu_resp_d;
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_read_en_q, mem_read_en_d;
    logic              mem_write_en_q, mem_write_en_d;
`ifdef BRIDGE_TIMEOUT_EN
    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              cpu_timeout_q, cpu_timeout_d;
`endif

    // Next-state and registered-output decode.
    always_comb begin
        state_d        = state_q;
        req_rw_d       = req_rw_q;
        req_addr_d     = req_addr_q;
        req_data_d     = req_data_q;
        wait_first_d   = 1'b0;
        cpu_din_d      = cpu_din_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_read_en_d  = 1'b0;
        mem_write_en_d = 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
        wait_cnt_d     = wait_cnt_q;
        cpu_timeout_d  = 1'b0;
`endif
        unique case (state_q)
            S_INIT: begin
                if (bus.mem_error)      state_d = S_FAULT;
                else if (!bus.mem_busy) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (bus.mem_error) begin
                    state_d = S_FAULT;
                end else if (bus.cpu_valid) begin
                    req_rw_d   = bus.cpu_rw;
                    req_addr_d = bus.cpu_addr;
                    req_data_d = bus.cpu_dout;
                    state_d    = S_ISSUE;
                    // Fire straight away so the enable is visible in the first ISSUE cycle.
                    if (!bus.mem_busy) begin
                        mem_read_en_d  = bus.cpu_rw;
                        mem_write_en_d = !bus.cpu_rw;
                        mem_addr_d     = bus.cpu_addr;
                        mem_wdata_d    = bus.cpu_dout;
                    end
                end
            end
            S_ISSUE: begin
                if (bus.mem_error) begin
                    state_d = S_FAULT;
                end else if (mem_read_en_q || mem_write_en_q) begin
                    state_d      = S_WAIT;
                    wait_first_d = 1'b1;
`ifdef BRIDGE_TIMEOUT_EN
                    wait_cnt_d   = '0;
`endif
                end else if (!bus.mem_busy) begin
                    mem_read_en_d  = req_rw_q;
                    mem_write_en_d = !req_rw_q;
                    mem_addr_d     = req_addr_q;
                    mem_wdata_d    = req_data_q;
                end
            end
            S_WAIT: begin
`ifdef BRIDGE_TIMEOUT_EN
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
`endif
                if (bus.mem_error) begin
                    state_d = S_FAULT;
                end else if (!wait_first_q && !bus.mem_busy) begin
                    state_d = S_RESP;
                    if (req_rw_q) cpu_din_d = bus.mem_rdata;
                end
`ifdef BRIDGE_TIMEOUT_EN
                else if (wait_cnt_q == CNT_LAST) begin
                    state_d       = S_RESP;
                    cpu_timeout_d = 1'b1;
                    cpu_din_d     = '1;
                end
`endif
            end
            S_RESP: begin
                state_d = bus.mem_error ? S_FAULT : S_IDLE;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
        rdy_d      = (state_d == S_IDLE);
        cpu_resp_d = (state_d == S_RESP);
        fault_d    = (state_d == S_FAULT);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_INIT;
            req_rw_q       <= 1'b0;
            req_addr_q     <= '0;
            req_data_q     <= '0;
            wait_first_q   <= 1'b0;
            rdy_q          <= 1'b0;
            cpu_din_q      <= '0;
            cpu_resp_q     <= 1'b0;
            fault_q        <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_read_en_q  <= 1'b0;
            mem_write_en_q <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
            wait_cnt_q     <= '0;
            cpu_timeout_q  <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            req_rw_q       <= req_rw_d;
            req_addr_q     <= req_addr_d;
            req_data_q     <= req_data_d;
            wait_first_q   <= wait_first_d;
            rdy_q          <= rdy_d;
            cpu_din_q      <= cpu_din_d;
            cpu_resp_q     <= cpu_resp_d;
            fault_q        <= fault_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_read_en_q  <= mem_read_en_d;
            mem_write_en_q <= mem_write_en_d;
`ifdef BRIDGE_TIMEOUT_EN
            wait_cnt_q     <= wait_cnt_d;
            cpu_timeout_q  <= cpu_timeout_d;
`endif
        end
    end

    assign bus.rdy          = rdy_q;
    assign bus.cpu_din      = cpu_din_q;
    assign bus.cpu_resp     = cpu_resp_q;
    assign bus.fault        = fault_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.mem_read_en  = mem_read_en_q;
    assign bus.mem_write_en = mem_write_en_q;
`ifdef BRIDGE_TIMEOUT_EN
    assign bus.cpu_timeout  = cpu_timeout_q;
`else
    assign bus.cpu_timeout  = 1'b0;
    // The timeout budget only has meaning when the timeout feature is built in.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

endmodule

// File: doc/cpu_mem_bridge.md
Name: cpu_mem_bridge

Overview:
- Sits directly upstream of the memory controller (memc) and converts 6502 core bus cycles into single memc requests.
- Holds the core off with rdy until memc finishes BIST, then serialises one access at a time.
- Captures read data and reports completion back to the core.
- Latches memc BIST failure into a sticky fault that stalls the core until reset.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 8, data width.
- TIMEOUT_CYCLES, 255, maximum WAIT-state cycles before a bus timeout (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cpu_valid  in  1  core requests an access this cycle
- cpu_rw  in  1  1 = read, 0 = write
- cpu_addr  in  ADDR_W  access address
- cpu_dout  in  DATA_W  write data from core
- rdy  out  1  bridge can accept a request
- cpu_din  out  DATA_W  read data to core
- cpu_resp  out  1  one-cycle completion pulse
- cpu_timeout  out  1  completion was a timeout (qualifies cpu_resp)
- fault  out  1  sticky memc BIST failure
- mem_addr  out  ADDR_W  request address to memc
- mem_wdata  out  DATA_W  write data to memc
- mem_read_en  out  1  one-cycle read request
- mem_write_en  out  1  one-cycle write request
- mem_busy  in  1  memc busy (BIST or access in progress)
- mem_rdata  in  DATA_W  memc read data
- mem_error  in  1  memc in BIST error state

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-low.
- Reset values of outputs: rdy=0, cpu_din=0, cpu_resp=0, cpu_timeout=0, fault=0, mem_addr=0, mem_wdata=0, mem_read_en=0, mem_write_en=0.
- Reset values of state: state=INIT; captured request registers cleared.
- Reset asserted mid-operation aborts immediately; any in-flight memc request is abandoned. memc is reset by the same signal.
- memc contract:
  - Request may be pulsed only while mem_busy=0.
  - mem_busy is high from the cycle after the request until completion, for at least one cycle.
  - Completion = first cycle mem_busy=0 after that; mem_rdata is valid in that cycle.
- One-hot FSM; all outputs registered.
- INIT: rdy=0.
  - mem_error=1 -> FAULT.
  - Otherwise mem_busy=0 -> IDLE.
  - Otherwise stay.
- IDLE: rdy=1.
  - cpu_valid=1 -> capture cpu_rw/cpu_addr/cpu_dout, drop rdy next cycle, -> ISSUE.
  - mem_error=1 takes priority over a request -> FAULT.
- ISSUE:
  - If mem_busy=0: pulse mem_read_en (rw=1) or mem_write_en (rw=0) for exactly one cycle, with mem_addr/mem_wdata driven from the captured values; -> WAIT.
  - Otherwise stay (no pulse).
- WAIT:
  - First cycle in WAIT ignores mem_busy (request-sampling cycle).
  - Afterwards mem_busy=0 -> RESP; capture mem_rdata into cpu_din for reads only.
  - Writes leave cpu_din unchanged.
- RESP: cpu_resp=1 for one cycle -> IDLE. rdy is 1 again the following cycle.
- FAULT: fault=1, rdy=0, no memc requests. Exit only via reset.
- mem_error seen in ISSUE, WAIT or RESP -> FAULT next cycle; no cpu_resp is issued for the in-flight access.
- Latency for accept at cycle T with minimal memc (1-cycle busy): mem_*_en at T+1, busy high at T+2, completion at T+3, cpu_resp at T+4, rdy=1 at T+5.
- cpu_valid while rdy=0 is ignored; no queueing, the core must hold its request.
- Back-to-back: a request at T+5 is accepted at T+5.
- Address and data pass through unmodified; no wrap or arithmetic.

Optional Feature:
- BRIDGE_TIMEOUT_EN defined:
  - Counter of width $clog2(TIMEOUT_CYCLES+1) runs in WAIT and is cleared on WAIT entry.
  - If mem_busy is still 1 when the counter reaches TIMEOUT_CYCLES -> RESP with cpu_timeout=1 and cpu_din=all-ones.
  - Completion and timeout in the same cycle resolve as normal completion.
- BRIDGE_TIMEOUT_EN undefined: no counter; cpu_timeout tied 0; WAIT holds indefinitely.

Test Plan:
- Reset release with mem_busy high for 20 cycles then low -> rdy=0 throughout; rdy=1 on the cycle after mem_busy falls.
- Read addr 16'h1234 with memc returning 8'hA5 after 1 busy cycle -> one-cycle mem_read_en with mem_addr=16'h1234 at T+1; cpu_resp with cpu_din=8'hA5 at T+4; cpu_timeout=0.
- Write 8'h3C to 16'hFFFF, then read 16'hFFFF -> one-cycle mem_write_en with mem_wdata=8'h3C; cpu_din unchanged on the write response; read returns 8'h3C; second request accepted at T+5.
- mem_busy still high when ISSUE is entered (e.g. 3 extra cycles) -> no enable pulse until mem_busy=0, then exactly one pulse.
- mem_error asserted in INIT, and separately during WAIT -> fault=1 and rdy=0 sticky, no cpu_resp; reset low clears both to 0 asynchronously.
- With BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_busy stuck high -> cpu_resp with cpu_timeout=1 and cpu_din=8'hFF after 4 WAIT cycles; rdy=1 the next cycle.
